// File: rtl/instruction_fetch.sv
// Instruction fetch: ROM bus initiator feeding a DEPTH-entry prefetch queue with valid/ready output.
// Optional macro IFETCH_STALL_COUNT_EN adds a saturating 16-bit consumer stall counter.
module instruction_fetch #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic                  rom_chip_select,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_address,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_address,
  input  logic                  instr_ready
`ifdef IFETCH_STALL_COUNT_EN
  ,
  output logic [15:0]           stall_count
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic                  cs_q, cs_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      rd_q, rd_d;
  logic [PTR_W-1:0]      wr_q, wr_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem_d [DEPTH];

  logic issue, push, pop;

  // Issue/capture/pop bookkeeping; redirect overrides everything but reset.
  always_comb begin
    cs_d       = cs_q;
    addr_d     = addr_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    data_mem_d = data_mem_q;
    addr_mem_d = addr_mem_q;

    // Conservative credit: an in-flight word reserves a slot, a same-cycle pop frees none.
    issue = enable && !redirect && ((cnt_q + CNT_W'(cs_q)) < CNT_W'(DEPTH));
    push  = cs_q && !redirect;
    pop   = valid_q && instr_ready && !redirect;

    if (redirect) begin
      cnt_d = '0;
      rd_d  = '0;
      wr_d  = '0;
      cs_d  = enable;
      if (enable) begin
        addr_d = redirect_address;
        pc_d   = redirect_address + ADDR_WIDTH'(1);
      end else begin
        pc_d   = redirect_address;
      end
    end else begin
      cs_d = issue;
      if (issue) begin
        addr_d = pc_q;
        pc_d   = pc_q + ADDR_WIDTH'(1);
      end
      if (push) begin
        data_mem_d[wr_q] = rom_data;
        addr_mem_d[wr_q] = addr_q;
        wr_d             = wr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_d = rd_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q       <= 1'b0;
      addr_q     <= '0;
      pc_q       <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      valid_q    <= 1'b0;
      data_mem_q <= '{default: '0};
      addr_mem_q <= '{default: '0};
    end else begin
      cs_q       <= cs_d;
      addr_q     <= addr_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      valid_q    <= valid_d;
      data_mem_q <= data_mem_d;
      addr_mem_q <= addr_mem_d;
    end
  end

  assign rom_chip_select = cs_q;
  assign rom_address     = addr_q;
  assign instr_valid     = valid_q;
  assign instr_data      = valid_q ? data_mem_q[rd_q] : '0;
  assign instr_address   = valid_q ? addr_mem_q[rd_q] : '0;

`ifdef IFETCH_STALL_COUNT_EN
  logic [15:0] stall_q, stall_d;

  // Counts edges where a word is offered but not taken; saturates, cleared only by reset.
  always_comb begin
    stall_d = stall_q;
    if (valid_q && !instr_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a combinational ROM model word[i]=A000_0000+i.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [4:0]  rom_address;
  logic        rom_chip_select;
  logic [31:0] rom_data;
  logic        redirect;
  logic [4:0]  redirect_address;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [4:0]  instr_address;
  logic        instr_ready;
`ifdef IFETCH_STALL_COUNT_EN
  logic [15:0] stall_count;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int pulses;
  logic [4:0] exp_a;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [4:0] a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  assign rom_data = rom_chip_select ? word_of(rom_address) : 32'h0;

  instruction_fetch dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .rom_address      (rom_address),
    .rom_chip_select  (rom_chip_select),
    .rom_data         (rom_data),
    .redirect         (redirect),
    .redirect_address (redirect_address),
    .instr_valid      (instr_valid),
    .instr_data       (instr_data),
    .instr_address    (instr_address),
    .instr_ready      (instr_ready)
`ifdef IFETCH_STALL_COUNT_EN
    ,
    .stall_count      (stall_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [4:0] a);
    check_eq({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check_eq({tag, "_addr"}, 32'(instr_address), 32'(a));
    check_eq({tag, "_data"}, instr_data, word_of(a));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_address = '0;
    tick(); tick();
    check_eq("rst_cs", 32'(rom_chip_select), 32'd0);
    check_eq("rst_raddr", 32'(rom_address), 32'd0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_data", instr_data, 32'd0);
    check_eq("rst_iaddr", 32'(instr_address), 32'd0);

    // Streaming from reset: select after one edge, first word after two.
    reset = 1'b0; enable = 1'b1; instr_ready = 1'b1;
    tick();
    check_eq("t1_cs", 32'(rom_chip_select), 32'd1);
    check_eq("t1_raddr", 32'(rom_address), 32'd0);
    check_eq("t1_valid_early", 32'(instr_valid), 32'd0);
    tick();
    for (int i = 0; i < 6; i++) begin
      check_head("t1_stream", 5'(i));
      tick();
    end

    // Backpressure: exactly DEPTH fetches, then resume without gap.
    reset = 1'b1; instr_ready = 1'b0;
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rom_chip_select) pulses++;
    end
    check_eq("t2_pulses", 32'(pulses), 32'd4);
    check_eq("t2_cs_idle", 32'(rom_chip_select), 32'd0);
    check_head("t2_hold", 5'd0);
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_head("t2_drain", 5'(i));
      tick();
    end

    // Redirect with non-empty queue and a fetch in flight.
    check_eq("t3_pre_cs", 32'(rom_chip_select), 32'd1);
    redirect = 1'b1; redirect_address = 5'd5;
    tick();
    redirect = 1'b0;
    check_eq("t3_valid", 32'(instr_valid), 32'd0);
    check_eq("t3_data0", instr_data, 32'd0);
    check_eq("t3_raddr", 32'(rom_address), 32'd5);
    check_eq("t3_cs", 32'(rom_chip_select), 32'd1);
    tick();
    for (int i = 5; i < 9; i++) begin
      check_head("t3_stream", 5'(i));
      tick();
    end

    // Redirect to the last address wraps to 0.
    redirect = 1'b1; redirect_address = 5'd31;
    tick();
    redirect = 1'b0;
    check_eq("t4_raddr", 32'(rom_address), 32'd31);
    tick();
    exp_a = 5'd31;
    for (int i = 0; i < 3; i++) begin
      check_head("t4_wrap", exp_a);
      exp_a = exp_a + 5'd1;
      tick();
    end
    check_head("t4_next", 5'd2);

    // Drop enable with a word in flight: it is still captured, nothing more issues.
    instr_ready = 1'b0; enable = 1'b0;
    tick();
    check_eq("t5_cs", 32'(rom_chip_select), 32'd0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rom_chip_select) pulses++;
    end
    check_eq("t5_pulses", 32'(pulses), 32'd0);
    check_eq("t5_raddr_hold", 32'(rom_address), 32'd3);
    check_head("t5_head", 5'd2);
    instr_ready = 1'b1;
    tick();
    check_head("t5_second", 5'd3);
    tick();
    check_eq("t5_empty", 32'(instr_valid), 32'd0);

    // Reset mid-stream.
    enable = 1'b1;
    tick(); tick(); tick();
    check_eq("t5_live", 32'(instr_valid), 32'd1);
    reset = 1'b1;
    tick();
    check_eq("t5_rst_cs", 32'(rom_chip_select), 32'd0);
    check_eq("t5_rst_raddr", 32'(rom_address), 32'd0);
    check_eq("t5_rst_valid", 32'(instr_valid), 32'd0);
    check_eq("t5_rst_data", instr_data, 32'd0);
    check_eq("t5_rst_iaddr", 32'(instr_address), 32'd0);

`ifdef IFETCH_STALL_COUNT_EN
    // Stall counter: counts unaccepted valid cycles, survives redirect, cleared by reset.
    reset = 1'b0; enable = 1'b1; instr_ready = 1'b0;
    tick(); tick();
    check_eq("t6_start", 32'(stall_count), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check_eq("t6_ten", 32'(stall_count), 32'd10);
    redirect = 1'b1; redirect_address = 5'd0;
    tick();
    redirect = 1'b0;
    check_eq("t6_redirect", 32'(stall_count), 32'd11);
    reset = 1'b1;
    tick();
    check_eq("t6_reset", 32'(stall_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
